simon_game_ctrl: RTL and testbench



---
 rtl/simon_game_pkg.sv | 27 ++
 rtl/game_lfsr.sv | 19 +
 rtl/simon_game_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_simon_game_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_game_pkg.sv
// Shared types and constants for the memory-game controller.
package simon_game_pkg;

    // Controller states; the 3-bit value is also driven out on o_State.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SHOW = 3'd1,
        ST_OFF  = 3'd2,
        ST_WAIT = 3'd3,
        ST_INCR = 3'd4,
        ST_WIN  = 3'd5,
        ST_LOSE = 3'd6
    } state_e;

    // Score display codes for the two terminal states.
    localparam logic [7:0] WIN_CODE  = 8'hAA;
    localparam logic [7:0] LOSE_CODE = 8'hEE;

    // Tap mask for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // XOR of the tapped bits: the bit shifted into the LFSR each clock.
    function automatic logic lfsr_feedback(input logic [31:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 32-bit Fibonacci LFSR used as the symbol source.
module game_lfsr
    import simon_game_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    output logic [31:0] o_Lfsr
);

    // Shift left every clock, inserting the tap parity; seed of 1 keeps it out of the all-zero lockup.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Lfsr <= 32'h0000_0001;
        end else begin
            o_Lfsr <= {o_Lfsr[30:0], lfsr_feedback(o_Lfsr)};
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Memory-game controller: shows a growing random sequence on the LEDs and
// checks the player's button releases against it.
module simon_game_ctrl
    import simon_game_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int MAX_LEN       = 8,
    parameter int CLKS_PER_STEP = 25000000,
    parameter int TIMEOUT_STEPS = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Start,
    input  logic [NUM_CH-1:0] i_Btn,
    output logic [NUM_CH-1:0] o_LED,
    output logic [7:0]        o_Score,
    output logic [2:0]        o_State,
    output logic              o_Win,
    output logic              o_Lose
);

    localparam int SYM_W = $clog2(NUM_CH);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // Pattern depth rounded up to a power of two so any index value selects a real entry.
    localparam int PAT_D = 1 << IDX_W;
    localparam int CNT_W = $clog2(CLKS_PER_STEP);
    localparam int TO_W  = (TIMEOUT_STEPS > 1) ? $clog2(TIMEOUT_STEPS) : 1;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(CLKS_PER_STEP - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_STEPS - 1);
    localparam logic [7:0]       MAX_SCORE = 8'(MAX_LEN);

    state_e              state, state_nxt;
    logic                armed;
    logic [CNT_W-1:0]    step_cnt;
    logic                step_tick;
    logic                counting;
    logic [TO_W-1:0]     to_cnt;
    logic                press_ok;
    logic [NUM_CH-1:0]   btn_q;
    logic [NUM_CH-1:0]   rel;
    logic [NUM_CH-1:0]   exp_led;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                idx_at_score;
    logic [7:0]          score, score_nxt;
    logic [SYM_W-1:0]    pattern [PAT_D];

    logic [31:0]         lfsr_word;
    logic [SYM_W-1:0]    lfsr_sym;
    // Only the low bits feed the symbol draw; the rest of the LFSR word is unneeded here.
    logic [31-SYM_W:0]   lfsr_unused_hi;

    game_lfsr u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .o_Lfsr  (lfsr_word)
    );

    assign lfsr_sym       = lfsr_word[SYM_W-1:0];
    assign lfsr_unused_hi = lfsr_word[31:SYM_W];

    assign counting     = (state == ST_SHOW) || (state == ST_OFF) || (state == ST_WAIT);
    assign step_tick    = counting && (step_cnt == STEP_LAST);
    assign rel          = btn_q & ~i_Btn;
    assign idx_at_score = (8'(idx) == score);
    assign o_State      = state;

    // One-hot image of the symbol at the current sequence position.
    always_comb begin
        exp_led = '0;
        exp_led[pattern[idx]] = 1'b1;
    end

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, index/score update and output decode.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        score_nxt = score;
        press_ok  = 1'b0;
        o_LED     = '0;
        o_Score   = score;
        o_Win     = 1'b0;
        o_Lose    = 1'b0;

        if (i_Start) begin
            // Restart overrides everything and lands in IDLE with a clean score.
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            score_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx_nxt   = '0;
                    score_nxt = '0;
                    if (armed) state_nxt = ST_SHOW;
                end
                ST_SHOW: begin
                    if (step_tick) state_nxt = ST_OFF;
                end
                ST_OFF: begin
                    if (step_tick) begin
                        if (idx_at_score) begin
                            idx_nxt   = '0;
                            state_nxt = ST_WAIT;
                        end else begin
                            idx_nxt   = idx + 1'b1;
                            state_nxt = ST_SHOW;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rel != '0) begin
                        // A wrong single release or any multi-button release both miss exp_led.
                        if (rel != exp_led) begin
                            state_nxt = ST_LOSE;
                        end else if (idx_at_score) begin
                            state_nxt = ST_INCR;
                        end else begin
                            idx_nxt  = idx + 1'b1;
                            press_ok = 1'b1;
                        end
                    end else if (step_tick && (to_cnt == TO_LAST)) begin
                        state_nxt = ST_LOSE;
                    end
                end
                ST_INCR: begin
                    score_nxt = score + 8'd1;
                    idx_nxt   = '0;
                    state_nxt = ((score + 8'd1) == MAX_SCORE) ? ST_WIN : ST_SHOW;
                end
                ST_WIN, ST_LOSE: begin
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                    score_nxt = '0;
                end
            endcase
        end

        case (state)
            ST_IDLE: o_LED = i_Btn;
            ST_SHOW: o_LED = exp_led;
            ST_WAIT: o_LED = i_Btn;
            ST_WIN: begin
                o_LED   = '1;
                o_Win   = 1'b1;
                o_Score = WIN_CODE;
            end
            ST_LOSE: begin
                o_Lose  = 1'b1;
                o_Score = LOSE_CODE;
            end
            default: begin
            end
        endcase
    end

    // Control registers: arming, sequence index, score, button history, timers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            armed    <= 1'b0;
            idx      <= '0;
            score    <= '0;
            btn_q    <= '0;
            step_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (i_Start) begin
                armed <= 1'b1;
            end else if ((state == ST_IDLE) && armed) begin
                armed <= 1'b0;
            end

            idx   <= idx_nxt;
            score <= score_nxt;
            btn_q <= i_Btn;

            if ((state_nxt != state) || !counting || step_tick) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end

            if ((state_nxt != state) || press_ok) begin
                to_cnt <= '0;
            end else if ((state == ST_WAIT) && step_tick) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Pattern shift register: refilled from the LFSR while idle, frozen during play.
    always_ff @(posedge i_Clk) begin
        if (state == ST_IDLE) begin
            pattern[0] <= lfsr_sym;
            for (int i = 1; i < PAT_D; i++) begin
                pattern[i] <= pattern[i-1];
            end
        end
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Directed self-checking bench for simon_game_ctrl (4 channels, 3 rounds, 4-clock steps).
module tb_simon_game_ctrl;

    localparam int NUM_CH        = 4;
    localparam int MAX_LEN       = 3;
    localparam int CLKS_PER_STEP = 4;
    localparam int TIMEOUT_STEPS = 2;

    localparam int S_IDLE = 0;
    localparam int S_SHOW = 1;
    localparam int S_OFF  = 2;
    localparam int S_WAIT = 3;
    localparam int S_INCR = 4;
    localparam int S_WIN  = 5;
    localparam int S_LOSE = 6;

    logic              i_Clk;
    logic              i_Rst_L;
    logic              i_Start;
    logic [NUM_CH-1:0] i_Btn;
    logic [NUM_CH-1:0] o_LED;
    logic [7:0]        o_Score;
    logic [2:0]        o_State;
    logic              o_Win;
    logic              o_Lose;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] seen [MAX_LEN];

    typedef struct {
        logic       rst_n;
        logic       start;
        logic [3:0] btn;
        logic [2:0] st;
        logic [7:0] score;
        logic       chk_led;
    } vec_t;

    vec_t vecs [8];

    simon_game_ctrl #(
        .NUM_CH        (NUM_CH),
        .MAX_LEN       (MAX_LEN),
        .CLKS_PER_STEP (CLKS_PER_STEP),
        .TIMEOUT_STEPS (TIMEOUT_STEPS)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Start (i_Start),
        .i_Btn   (i_Btn),
        .o_LED   (o_LED),
        .o_Score (o_Score),
        .o_State (o_State),
        .o_Win   (o_Win),
        .o_Lose  (o_Lose)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string name, input int exp);
        check(name, 32'(o_State), 32'(exp));
    endtask

    task automatic cyc();
        @(negedge i_Clk);
    endtask

    task automatic chk_lose(input string name);
        chk_state({name, "_state"}, S_LOSE);
        check({name, "_score"}, 32'(o_Score), 32'hEE);
        check({name, "_lose"}, 32'(o_Lose), 32'd1);
        check({name, "_win"}, 32'(o_Win), 32'd0);
        check({name, "_led"}, 32'(o_LED), 32'd0);
    endtask

    // Called with SHOW observed; returns with WAIT observed.
    task automatic watch(input int r);
        for (int k = 0; k <= r; k++) begin
            for (int c = 0; c < CLKS_PER_STEP; c++) begin
                chk_state("show_state", S_SHOW);
                check("show_onehot", 32'($onehot(o_LED)), 32'd1);
                if (c == 0 && k == r) seen[k] = o_LED;
                else check("show_symbol", 32'(o_LED), 32'(seen[k]));
                cyc();
            end
            for (int c = 0; c < CLKS_PER_STEP; c++) begin
                chk_state("off_state", S_OFF);
                check("off_led", 32'(o_LED), 32'd0);
                cyc();
            end
        end
        chk_state("wait_entry", S_WAIT);
    endtask

    // Hold buttons for one clock, then release them.
    task automatic press(input logic [3:0] b);
        i_Btn = b;
        cyc();
        check("wait_led_mirror", 32'(o_LED), 32'(b));
        i_Btn = 4'h0;
        cyc();
    endtask

    task automatic play_round(input int r);
        watch(r);
        for (int k = 0; k <= r; k++) begin
            press(seen[k]);
            if (k < r) chk_state("mid_press_wait", S_WAIT);
            else       chk_state("incr_state", S_INCR);
        end
        check("incr_score_before", 32'(o_Score), 32'(r));
        cyc();
        if (r + 1 == MAX_LEN) begin
            chk_state("win_state", S_WIN);
            check("win_score", 32'(o_Score), 32'hAA);
            check("win_flag", 32'(o_Win), 32'd1);
            check("win_led", 32'(o_LED), 32'hF);
        end else begin
            chk_state("next_round_show", S_SHOW);
            check("round_score", 32'(o_Score), 32'(r + 1));
        end
    endtask

    // Three-cycle start pulse from any state; returns with SHOW observed.
    task automatic start_game();
        i_Start = 1'b1;
        cyc();
        chk_state("restart_idle", S_IDLE);
        check("restart_score", 32'(o_Score), 32'd0);
        check("restart_flags", {30'd0, o_Win, o_Lose}, 32'd0);
        cyc();
        cyc();
        i_Start = 1'b0;
        chk_state("start_held_idle", S_IDLE);
        cyc();
        chk_state("start_show", S_SHOW);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 4'h0, 3'd0, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 4'h3, 3'd0, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 4'h5, 3'd0, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 4'h0, 3'd0, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 4'h0, 3'd0, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 4'h0, 3'd0, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 4'h0, 3'd0, 8'h00, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 4'h0, 3'd1, 8'h00, 1'b0};

        i_Rst_L = 1'b0;
        i_Start = 1'b0;
        i_Btn   = 4'h0;

        // Reset and idle rows of the table
        for (int i = 0; i < 4; i++) begin
            i_Rst_L = vecs[i].rst_n;
            i_Start = vecs[i].start;
            i_Btn   = vecs[i].btn;
            cyc();
            chk_state("vec_state", int'(vecs[i].st));
            check("vec_score", 32'(o_Score), 32'(vecs[i].score));
            check("vec_flags", {30'd0, o_Win, o_Lose}, 32'd0);
            if (vecs[i].chk_led) check("vec_led", 32'(o_LED), 32'(vecs[i].btn));
        end

        // No start for 100 cycles: stays idle, LEDs follow buttons
        for (int i = 0; i < 100; i++) begin
            i_Btn = 4'(i);
            cyc();
            chk_state("idle_hold", S_IDLE);
            check("idle_score", 32'(o_Score), 32'd0);
            check("idle_led", 32'(o_LED), 32'(i_Btn));
        end
        i_Btn = 4'h0;

        // Start pulse rows of the table
        for (int i = 4; i < 8; i++) begin
            i_Rst_L = vecs[i].rst_n;
            i_Start = vecs[i].start;
            i_Btn   = vecs[i].btn;
            cyc();
            chk_state("vec_state", int'(vecs[i].st));
            check("vec_score", 32'(o_Score), 32'(vecs[i].score));
            check("vec_flags", {30'd0, o_Win, o_Lose}, 32'd0);
            if (vecs[i].chk_led) check("vec_led", 32'(o_LED), 32'(vecs[i].btn));
        end

        // Full game to WIN, then hold
        for (int r = 0; r < MAX_LEN; r++) play_round(r);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_state("win_hold", S_WIN);
            check("win_hold_score", 32'(o_Score), 32'hAA);
        end

        // Wrong button release
        start_game();
        watch(0);
        press({seen[0][2:0], seen[0][3]});
        chk_lose("wrong_btn");
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_state("lose_hold", S_LOSE);
        end

        // Two buttons released together (one of them correct)
        start_game();
        watch(0);
        press(seen[0] | {seen[0][2:0], seen[0][3]});
        chk_lose("double_btn");

        // Timeout with no press: 8 clocks of WAIT then LOSE
        start_game();
        watch(0);
        for (int n = 0; n < 8; n++) begin
            chk_state("timeout_wait", S_WAIT);
            cyc();
        end
        chk_lose("timeout");

        // Mid-sequence press at clock 6 clears the timeout
        start_game();
        play_round(0);
        watch(1);
        for (int n = 0; n < 4; n++) begin
            chk_state("to_clear_wait", S_WAIT);
            cyc();
        end
        chk_state("to_clear_wait", S_WAIT);
        i_Btn = seen[0];
        cyc();
        chk_state("to_clear_wait", S_WAIT);
        i_Btn = 4'h0;
        cyc();
        for (int n = 6; n < 12; n++) begin
            chk_state("to_clear_still_wait", S_WAIT);
            cyc();
        end
        chk_lose("to_clear_expire");

        // Asynchronous reset mid-SHOW, away from any clock edge
        start_game();
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk_state("async_rst_state", S_IDLE);
        check("async_rst_score", 32'(o_Score), 32'd0);
        check("async_rst_led", 32'(o_LED), 32'd0);
        check("async_rst_flags", {30'd0, o_Win, o_Lose}, 32'd0);
        cyc();
        cyc();
        i_Rst_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_state("post_rst_idle", S_IDLE);
        end

        // Start asserted during OFF
        start_game();
        for (int c = 0; c < CLKS_PER_STEP; c++) cyc();
        chk_state("off_before_start", S_OFF);
        i_Start = 1'b1;
        cyc();
        chk_state("start_in_off_idle", S_IDLE);
        i_Start = 1'b0;
        cyc();
        chk_state("start_in_off_show", S_SHOW);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
